// File: rtl/boot_run_sequencer_if.sv
// Signal bundle linking the boot/run sequencer to its controller, program source, imem and core.
// The master modport is the sequencer's view; the slave modport is the environment's view.
interface boot_run_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int TMO_W  = 16
);
  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic [TMO_W-1:0]  timeout_cyc;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              core_reset_x;
  logic              commit_valid;
  logic [31:0]       commit_pc;
  logic              busy;
  logic              done;
  logic              halted;
  logic              timed_out;

  modport master (
    input  start, prog_len, timeout_cyc, src_valid, src_data, commit_valid, commit_pc,
    output src_ready, imem_we, imem_addr, imem_wdata, core_reset_x, busy, done, halted, timed_out
  );

  modport slave (
    output start, prog_len, timeout_cyc, src_valid, src_data, commit_valid, commit_pc,
    input  src_ready, imem_we, imem_addr, imem_wdata, core_reset_x, busy, done, halted, timed_out
  );
endinterface

// File: rtl/boot_run_sequencer.sv
// Loads a program into imem while the core is held in reset, releases the core, then ends the
// run on a repeated-PC halt idiom or a cycle watchdog and reports which one ended it.
module boot_run_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 4,
  parameter int HALT_REP   = 4,
  parameter int TMO_W      = 16
) (
  input logic                  clk,
  input logic                  reset_x,
  boot_run_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]  MAX_LEN     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  ONE_LEN     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [TMO_W-1:0] ONE_TMO     = {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0]       REP_MAX     = 4'(HALT_REP);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_wcnt;
  logic [TMO_W-1:0]  r_tmo;
  logic [TMO_W-1:0]  r_cyc;
  logic [3:0]        r_settle;
  logic [3:0]        r_rep;
  logic [31:0]       r_last_pc;
  logic              r_seen;
  logic              r_halted;
  logic              r_timed_out;
  logic              r_core_reset_x;

  logic [ADDR_W:0]   w_len_sat;
  logic              w_start;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_same_pc;
  logic [3:0]        w_rep_next;
  logic              w_halt_hit;
  logic              w_tmo_hit;
  logic [DATA_W-1:0] w_wdata;

  // Oversized programs are clipped to the imem depth so the write address never wraps.
  assign w_len_sat   = (bus.prog_len > MAX_LEN) ? MAX_LEN : bus.prog_len;
  assign w_start     = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
  assign w_beat      = (r_state == S_LOAD) && bus.src_valid;
  assign w_last_beat = w_beat && (r_wcnt == (r_len - ONE_LEN));

  // The first commit of a run has no previous PC to match, so it always restarts the count.
  assign w_same_pc  = r_seen && (bus.commit_pc == r_last_pc);
  assign w_rep_next = !w_same_pc         ? 4'd1  :
                      (r_rep == REP_MAX) ? r_rep : r_rep + 4'd1;
  assign w_halt_hit = (r_state == S_RUN) && bus.commit_valid && (w_rep_next == REP_MAX);
  assign w_tmo_hit  = (r_state == S_RUN) && (r_tmo != '0) && (r_cyc == (r_tmo - ONE_TMO));

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_next_state = (bus.prog_len == '0) ? S_SETTLE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_last_beat) begin
          w_next_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_settle == SETTLE_LAST) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_halt_hit || w_tmo_hit) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.src_ready = 1'b0;
    bus.imem_we   = 1'b0;
    bus.imem_addr = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      S_LOAD: begin
        bus.src_ready = 1'b1;
        bus.imem_we   = bus.src_valid;
        bus.imem_addr = r_wcnt[ADDR_W-1:0];
        bus.busy      = 1'b1;
      end
      S_SETTLE, S_RUN: begin
        bus.busy = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign w_wdata          = bus.src_data;
  assign bus.imem_wdata   = w_wdata;
  assign bus.core_reset_x = r_core_reset_x;
  assign bus.halted       = r_halted;
  assign bus.timed_out    = r_timed_out;

  // Core reset follows the next state so the core leaves reset exactly on the first RUN cycle.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      r_len          <= '0;
      r_wcnt         <= '0;
      r_tmo          <= '0;
      r_cyc          <= '0;
      r_settle       <= '0;
      r_rep          <= '0;
      r_last_pc      <= '0;
      r_seen         <= 1'b0;
      r_halted       <= 1'b0;
      r_timed_out    <= 1'b0;
      r_core_reset_x <= 1'b0;
    end else begin
      r_core_reset_x <= (w_next_state == S_RUN);
      r_settle       <= (r_state == S_SETTLE) ? r_settle + 4'd1 : 4'd0;
      r_cyc          <= (r_state == S_RUN) ? r_cyc + ONE_TMO : '0;
      if (w_start) begin
        r_len       <= w_len_sat;
        r_tmo       <= bus.timeout_cyc;
        r_wcnt      <= '0;
        r_rep       <= '0;
        r_last_pc   <= '0;
        r_seen      <= 1'b0;
        r_halted    <= 1'b0;
        r_timed_out <= 1'b0;
      end
      if (w_beat) begin
        r_wcnt <= r_wcnt + ONE_LEN;
      end
      if ((r_state == S_RUN) && bus.commit_valid) begin
        r_rep     <= w_rep_next;
        r_last_pc <= bus.commit_pc;
        r_seen    <= 1'b1;
      end
      // Halt detection takes priority when it coincides with the watchdog expiring.
      if (w_halt_hit) begin
        r_halted <= 1'b1;
      end else if (w_tmo_hit) begin
        r_timed_out <= 1'b1;
      end
    end
  end

endmodule
